// File: rtl/angle_frame_parser.sv
// angle_frame_parser: pulls bytes from a FIFO, locks on HEADER and emits N_POINTS {hi,lo} angles on valid/ready.
// Define ANGLE_FRAME_CHECKSUM_EN to append and verify a trailing XOR checksum byte per frame.
module angle_frame_parser #(
    parameter logic [7:0] HEADER   = 8'hFA,
    parameter int         N_POINTS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        empty,
    output logic        re,
    output logic [15:0] angle,
    output logic [3:0]  angle_idx,
    output logic        angle_valid,
    input  logic        angle_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);
`ifdef ANGLE_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, HI, LO, CHK} state_t;
`else
    typedef enum logic [1:0] {HUNT, HI, LO} state_t;
`endif
    localparam logic [3:0] LAST = 4'(N_POINTS - 1);
    state_t      r_state;
    logic        r_pend, r_held, r_valid, r_ok;
    logic [7:0]  r_hi, r_lo;
    logic [3:0]  r_idx, r_aidx;
    logic [15:0] r_angle;
`ifdef ANGLE_FRAME_CHECKSUM_EN
    logic [7:0]  r_sum, r_cnt;
    logic        r_err;
`endif
    logic        w_stall, w_take;
    logic [7:0]  w_byte;
    assign w_stall = r_valid && !angle_ready;
    // a LO byte arriving while the previous angle is unaccepted waits in r_lo
    assign w_take  = (r_pend || r_held) && !(r_state == LO && w_stall);
    assign w_byte  = r_held ? r_lo : din;
    assign re      = rst && !empty && !r_pend && !r_held && !w_stall;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HUNT;
            r_pend  <= 1'b0;
            r_held  <= 1'b0;
            r_valid <= 1'b0;
            r_ok    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_idx   <= '0;
            r_aidx  <= '0;
            r_angle <= '0;
`ifdef ANGLE_FRAME_CHECKSUM_EN
            r_sum   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_pend <= re;
            r_ok   <= 1'b0;
`ifdef ANGLE_FRAME_CHECKSUM_EN
            r_err  <= 1'b0;
`endif
            if (r_valid && angle_ready) r_valid <= 1'b0;
            if (r_pend && !w_take) begin
                r_held <= 1'b1;
                r_lo   <= din;
            end
            if (w_take) begin
                r_held <= 1'b0;
                case (r_state)
                    HUNT: if (w_byte == HEADER) begin
                        r_state <= HI;
                        r_idx   <= '0;
`ifdef ANGLE_FRAME_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                    HI: begin
                        r_hi    <= w_byte;
                        r_state <= LO;
`ifdef ANGLE_FRAME_CHECKSUM_EN
                        r_sum   <= r_sum ^ w_byte;
`endif
                    end
                    LO: begin
                        r_angle <= {r_hi, w_byte};
                        r_aidx  <= r_idx;
                        r_valid <= 1'b1;
                        r_idx   <= r_idx + 4'd1;
`ifdef ANGLE_FRAME_CHECKSUM_EN
                        r_sum   <= r_sum ^ w_byte;
                        r_state <= (r_idx == LAST) ? CHK : HI;
`else
                        r_ok    <= (r_idx == LAST);
                        r_state <= (r_idx == LAST) ? HUNT : HI;
`endif
                    end
`ifdef ANGLE_FRAME_CHECKSUM_EN
                    CHK: begin
                        r_ok    <= (w_byte == r_sum);
                        r_err   <= (w_byte != r_sum);
                        r_cnt   <= (w_byte != r_sum && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
                        r_state <= HUNT;
                    end
`endif
                    default: r_state <= HUNT;
                endcase
            end
        end
    end
    assign angle       = r_angle;
    assign angle_idx   = r_aidx;
    assign angle_valid = r_valid;
    assign frame_ok    = r_ok;
`ifdef ANGLE_FRAME_CHECKSUM_EN
    assign frame_err   = r_err;
    assign err_cnt     = r_cnt;
`else
    assign frame_err   = 1'b0;
    assign err_cnt     = 8'd0;
`endif
endmodule

// File: tb/tb_angle_frame_parser.sv
// tb_angle_frame_parser: directed frames through a FIFO model with hand-derived angle/status expectations.
`timescale 1ns/1ps
module tb_angle_frame_parser;
    localparam int NP = 12;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        empty = 1'b1;
    logic        re;
    logic [15:0] angle;
    logic [3:0]  angle_idx;
    logic        angle_valid;
    logic        angle_ready = 1'b1;
    logic        frame_ok, frame_err;
    logic [7:0]  err_cnt;
    logic        gate = 1'b0;
    logic [7:0]  q[$];
    logic [15:0] rx_ang[$];
    logic [3:0]  rx_idx[$];
    int ok_cnt = 0, err_p = 0, re_cnt = 0;
    int n_chk = 0, n_err = 0;

    angle_frame_parser dut (
        .clk(clk), .rst(rst), .din(din), .empty(empty), .re(re),
        .angle(angle), .angle_idx(angle_idx), .angle_valid(angle_valid),
        .angle_ready(angle_ready), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, registered empty flag
    always @(posedge clk) begin
        if (re) din <= q.pop_front();
        empty <= (q.size() == 0) || gate;
    end

    always @(negedge clk) begin
        if (angle_valid && angle_ready) begin
            rx_ang.push_back(angle);
            rx_idx.push_back(angle_idx);
        end
        if (frame_ok) ok_cnt++;
        if (frame_err) err_p++;
        if (re) re_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_ang(input logic [7:0] b, input int k);
        logic [7:0] h;
        h = b + 8'(2 * k);
        return {h, h + 8'd1};
    endfunction

    task automatic push_frame(input logic [7:0] base, input logic [7:0] bad);
        logic [7:0] s;
        s = 8'h00;
        q.push_back(8'hFA);
        for (int k = 0; k < NP; k++) begin
            q.push_back(exp_ang(base, k)[15:8]);
            q.push_back(exp_ang(base, k)[7:0]);
            s = s ^ exp_ang(base, k)[15:8] ^ exp_ang(base, k)[7:0];
        end
`ifdef ANGLE_FRAME_CHECKSUM_EN
        q.push_back(s ^ bad);
`else
        if (bad != 8'h00) q.push_back(s ^ bad);
`endif
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while ((ok_cnt + err_p) < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        if ((ok_cnt + err_p) < n) chk("frame_timeout", ok_cnt + err_p, n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] base, input int start);
        chk({tag, "_count"}, rx_ang.size() - start, NP);
        for (int k = 0; k < NP && start + k < rx_ang.size(); k++) begin
            chk({tag, "_ang"}, rx_ang[start + k], exp_ang(base, k));
            chk({tag, "_idx"}, rx_idx[start + k], k);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_re"}, re, 0);
        chk({tag, "_angle"}, angle, 0);
        chk({tag, "_idx"}, angle_idx, 0);
        chk({tag, "_valid"}, angle_valid, 0);
        chk({tag, "_ok"}, frame_ok, 0);
        chk({tag, "_err"}, frame_err, 0);
        chk({tag, "_errcnt"}, err_cnt, 0);
    endtask

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!angle_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!angle_valid) chk({tag, "_timeout"}, angle_valid, 1);
    endtask

    initial begin
        int s, ok0, er0, rc0, t;
        // reset at start, with bytes already waiting in the FIFO
        q.push_back(8'h55);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst0");
        q.delete();
        @(posedge clk); #1 rst = 1'b1;
        // partial frame (header + 4 bytes), then reset mid-frame
        q.push_back(8'hFA); q.push_back(8'h11); q.push_back(8'h22);
        q.push_back(8'h33); q.push_back(8'h44);
        t = 0;
        while (q.size() != 0 && t < 100) begin @(posedge clk); t++; end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_angle", angle, 16'h3344);
        chk("mid_idx", angle_idx, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        @(posedge clk); #1 rst = 1'b1;
        s = rx_ang.size(); ok0 = ok_cnt; er0 = err_p;
        push_frame(8'h40, 8'h00);
        wait_frames(ok0 + er0 + 1, 500);
        check_frame("resync", 8'h40, s);
        chk("resync_ok", ok_cnt - ok0, 1);
        // counting frame 01 02, 03 04 ... 17 18
        s = rx_ang.size(); ok0 = ok_cnt; er0 = err_p;
        push_frame(8'h01, 8'h00);
        wait_frames(ok0 + er0 + 1, 500);
        check_frame("count", 8'h01, s);
        chk("count_first", rx_ang[s], 16'h0102);
        chk("count_last", rx_ang[s + NP - 1], 16'h1718);
        chk("count_ok", ok_cnt - ok0, 1);
        chk("count_noerr", err_p - er0, 0);
        chk("count_errcnt", err_cnt, 0);
`ifdef ANGLE_FRAME_CHECKSUM_EN
        // corrupted checksum, then saturation of the error counter
        s = rx_ang.size(); ok0 = ok_cnt; er0 = err_p;
        push_frame(8'h01, 8'h01);
        wait_frames(ok0 + er0 + 1, 500);
        check_frame("badcs", 8'h01, s);
        chk("badcs_err", err_p - er0, 1);
        chk("badcs_ok", ok_cnt - ok0, 0);
        chk("badcs_errcnt", err_cnt, 1);
        for (int i = 0; i < 299; i++) push_frame(8'h01, 8'h01);
        wait_frames(ok0 + er0 + 300, 20000);
        chk("sat_pulses", err_p - er0, 300);
        chk("sat_errcnt", err_cnt, 255);
`endif
        // leading garbage, payload containing the header value
        s = rx_ang.size(); ok0 = ok_cnt; er0 = err_p;
        q.push_back(8'h00); q.push_back(8'h55);
        push_frame(8'hF0, 8'h00);
        wait_frames(ok0 + er0 + 1, 500);
        check_frame("garbage", 8'hF0, s);
        chk("garbage_ok", ok_cnt - ok0, 1);
        chk("garbage_err", err_p - er0, 0);
        // downstream stall at idx 3
        s = rx_ang.size(); ok0 = ok_cnt; er0 = err_p;
        angle_ready = 1'b0;
        push_frame(8'h80, 8'h00);
        for (int p = 0; p < NP; p++) begin
            wait_valid("stall_wait");
            if (p == 3) begin
                rc0 = re_cnt;
                repeat (20) @(negedge clk);
                chk("stall_angle", angle, 16'h8687);
                chk("stall_idx", angle_idx, 3);
                chk("stall_valid", angle_valid, 1);
                chk("stall_re", re_cnt - rc0, 0);
            end
            @(posedge clk); #1 angle_ready = 1'b1;
            @(posedge clk); #1 angle_ready = 1'b0;
        end
        angle_ready = 1'b1;
        wait_frames(ok0 + er0 + 1, 500);
        check_frame("stall", 8'h80, s);
        chk("stall_ok", ok_cnt - ok0, 1);
        // FIFO empty toggling every 3 cycles
        s = rx_ang.size(); ok0 = ok_cnt; er0 = err_p;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat (3) @(posedge clk);
                    #1 gate = ~gate;
                end
                gate = 1'b0;
            end
        join_none
        push_frame(8'h30, 8'h00);
        wait_frames(ok0 + er0 + 1, 1000);
        check_frame("toggle", 8'h30, s);
        chk("toggle_ok", ok_cnt - ok0, 1);
        chk("toggle_err", err_p - er0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
